socetlib_debouncer: RTL and testbench
=====================================

Name: socetlib_debouncer

Overview:
Conditions raw, asynchronous, possibly bouncy inputs such as buttons, straps and external IRQ lines into clean signals in the CLK domain. It has a per-bit N-flop synchronizer followed by a per-bit stability counter. Its stable_out is the intended direct source for socetlib_edge_detector.signal, so downstream edge pulses are glitch-free and metastability-safe.

Parameters:
WIDTH, 1, number of independent input bits.
SYNC_STAGES, 2, synchronizer flop depth. Must be >=2; elaboration error otherwise.
STABLE_CYCLES, 16, sample ticks a new level must persist before being accepted. Must be >=1; elaboration error otherwise.
RESET_VAL, 0 (WIDTH bits), reset value of the synchronizer chain and stable_out.

Ports:
CLK  input  1  clock.
nRST  input  1  reset, asynchronous, active-low.
async_in  input  WIDTH  raw asynchronous inputs.
sample_tick  input  1  qualifies counter advance. Tie to 1 to count every CLK.
stable_out  output  WIDTH  debounced, synchronized level.
settling  output  WIDTH  per-bit flag: synchronized input differs from stable_out and is being timed.

Behaviour:
- Reset (nRST=0, async): all synchronizer flops = RESET_VAL; stable_out = RESET_VAL; all counters = 0; settling = 0.
- Synchronizer: sync[0] <= async_in; sync[k] <= sync[k-1]. s = sync[SYNC_STAGES-1]. No other logic touches the sync chain.
- Each bit i runs an independent 2-state FSM: STABLE or SETTLING. Counter width is $clog2(STABLE_CYCLES+1).
- STABLE, s[i]==stable_out[i]: hold; cnt=0.
- STABLE, s[i]!=stable_out[i]: go to SETTLING. If sample_tick=1, cnt<=1; else cnt<=0.
- SETTLING, s[i]==stable_out[i] (bounce back): go to STABLE; cnt<=0; stable_out unchanged. This holds regardless of sample_tick.
- SETTLING, s[i]!=stable_out[i], sample_tick=1: cnt<=cnt+1.
- SETTLING, s[i]!=stable_out[i], sample_tick=0: cnt holds.
- Acceptance: when an increment would make cnt==STABLE_CYCLES, on that edge stable_out[i]<=s[i], cnt<=0, state<=STABLE.
  - This includes STABLE_CYCLES=1, where the accept happens on the STABLE->SETTLING transition edge itself with sample_tick=1, and the FSM stays STABLE.
- Counter never exceeds STABLE_CYCLES; no wrap possible.
- settling[i] = (state==SETTLING), registered from the FSM state.
- Latency, with sample_tick=1 and a clean step: stable_out changes on the (SYNC_STAGES+STABLE_CYCLES)th rising CLK edge after the first edge that samples the new level. Defaults give 18 edges.
- Glitch rejection: a level lasting fewer than STABLE_CYCLES qualifying ticks after synchronization never reaches stable_out.
- Bits are fully independent. Simultaneous transitions on multiple bits are timed separately.
- Reset mid-settle: all in-flight counts are discarded. After release, stable_out=RESET_VAL, and any differing input restarts a full count.

Optional Feature:
Macro SOCETLIB_DEBOUNCER_EDGE_EN.
- Defined: adds outputs rise_pulse[WIDTH] and fall_pulse[WIDTH].
  - Registered, one CLK wide, asserted in the same cycle stable_out[i] takes its new value (0->1 and 1->0 respectively).
  - Generated from the accept event, not from comparing stable_out.
  - Reset value 0.
  - A bit can never pulse on consecutive cycles when STABLE_CYCLES>=2.
- Undefined: ports and logic are absent. Edges are obtained by feeding stable_out into socetlib_edge_detector.

Test Plan:
1. Clean step: WIDTH=1, defaults, tick=1, async_in 0->1 held. Required: stable_out=1 exactly 18 edges later; settling high for edges 3..17 only.
2. Glitch rejection: async_in=1 for 10 cycles, then 0. Required: stable_out stays 0; settling drops within 1 cycle of s returning to 0; cnt returns to 0.
3. Tick gating: STABLE_CYCLES=4, sample_tick pulsed every 4th CLK, async_in 0->1 held. Required: stable_out=1 on the 4th tick after s changed; no change while tick=0.
4. Reset mid-settle: RESET_VAL=0, async_in=1, assert nRST at count 10, release. Required: stable_out=0 immediately; after release, 1 again exactly 18 edges later.
5. Multi-bit: WIDTH=4, bit0 steps at t=0, bit3 at t=5, bit1 bounces with 3-cycle pulses. Required: bit0 changes at 18, bit3 at 23, bit1 never changes.
6. With SOCETLIB_DEBOUNCER_EDGE_EN defined, rise then fall step. Required: single-cycle rise_pulse coincident with stable_out 0->1; single-cycle fall_pulse coincident with 1->0; no pulses during bounces.

Source files
------------

// File: rtl/socetlib_debouncer.sv
// Per-bit synchronizer plus stability-counter debouncer for raw asynchronous inputs.
// Define SOCETLIB_DEBOUNCER_EDGE_EN to add registered rise_pulse/fall_pulse outputs.
module socetlib_debouncer #(
  parameter int unsigned      WIDTH         = 1,
  parameter int unsigned      SYNC_STAGES   = 2,
  parameter int unsigned      STABLE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] async_in,
  input  logic             sample_tick,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] settling
`ifdef SOCETLIB_DEBOUNCER_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
`endif
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_e;

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("socetlib_debouncer: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $error("socetlib_debouncer: STABLE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  state_e           state [WIDTH];
  logic [CW-1:0]    cnt   [WIDTH];

  // Plain synchronizer chain; nothing else reads or writes these flops except the last stage.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VAL;
    end else begin
      sync_q[0] <= async_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Independent per-bit STABLE/SETTLING machines; acceptance fires when the count would reach STABLE_CYCLES.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stable_out <= RESET_VAL;
      settling   <= '0;
`ifdef SOCETLIB_DEBOUNCER_EDGE_EN
      rise_pulse <= '0;
      fall_pulse <= '0;
`endif
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= '0;
      end
    end else begin
`ifdef SOCETLIB_DEBOUNCER_EDGE_EN
      rise_pulse <= '0;
      fall_pulse <= '0;
`endif
      for (int i = 0; i < WIDTH; i++) begin
        if (state[i] == STABLE) begin
          if (s[i] != stable_out[i]) begin
            // A one-tick window accepts on the very edge the difference is first seen.
            if (sample_tick && (STABLE_CYCLES == 1)) begin
              stable_out[i] <= s[i];
              cnt[i]        <= '0;
`ifdef SOCETLIB_DEBOUNCER_EDGE_EN
              rise_pulse[i] <= s[i];
              fall_pulse[i] <= ~s[i];
`endif
            end else begin
              state[i]    <= SETTLING;
              settling[i] <= 1'b1;
              cnt[i]      <= sample_tick ? CW'(1) : '0;
            end
          end else begin
            cnt[i] <= '0;
          end
        end else begin
          if (s[i] == stable_out[i]) begin
            state[i]    <= STABLE;
            settling[i] <= 1'b0;
            cnt[i]      <= '0;
          end else if (sample_tick) begin
            if (cnt[i] == LAST) begin
              stable_out[i] <= s[i];
              state[i]      <= STABLE;
              settling[i]   <= 1'b0;
              cnt[i]        <= '0;
`ifdef SOCETLIB_DEBOUNCER_EDGE_EN
              rise_pulse[i] <= s[i];
              fall_pulse[i] <= ~s[i];
`endif
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_socetlib_debouncer.sv
// Bench for socetlib_debouncer: three configurations checked each cycle against a run-length model.
module tb_socetlib_debouncer;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [3:0] async_in;
  logic       sample_tick;

  logic [3:0] so_a, st_a, so_b, st_b;
  logic [0:0] so_c, st_c;
`ifdef SOCETLIB_DEBOUNCER_EDGE_EN
  logic [3:0] rp_a, fp_a, rp_b, fp_b;
  logic [0:0] rp_c, fp_c;
`endif

  localparam logic [3:0] RV_B = 4'b1010;
  localparam logic [0:0] RV_C = 1'b1;

  // Instance parameters as seen by the model: 0 = defaults x4, 1 = short window, 2 = one-tick window.
  localparam int         SC [3] = '{16, 4, 1};
  localparam int         NS [3] = '{2, 3, 2};
  localparam int         WD [3] = '{4, 4, 1};
  localparam logic [3:0] RV [3] = '{4'b0000, 4'b1010, 4'b0001};

  socetlib_debouncer #(.WIDTH(4), .SYNC_STAGES(2), .STABLE_CYCLES(16), .RESET_VAL(4'b0000)) dut_a (
    .CLK(CLK), .nRST(nRST), .async_in(async_in), .sample_tick(sample_tick),
    .stable_out(so_a), .settling(st_a)
`ifdef SOCETLIB_DEBOUNCER_EDGE_EN
    , .rise_pulse(rp_a), .fall_pulse(fp_a)
`endif
  );

  socetlib_debouncer #(.WIDTH(4), .SYNC_STAGES(3), .STABLE_CYCLES(4), .RESET_VAL(RV_B)) dut_b (
    .CLK(CLK), .nRST(nRST), .async_in(async_in), .sample_tick(sample_tick),
    .stable_out(so_b), .settling(st_b)
`ifdef SOCETLIB_DEBOUNCER_EDGE_EN
    , .rise_pulse(rp_b), .fall_pulse(fp_b)
`endif
  );

  socetlib_debouncer #(.WIDTH(1), .SYNC_STAGES(2), .STABLE_CYCLES(1), .RESET_VAL(RV_C)) dut_c (
    .CLK(CLK), .nRST(nRST), .async_in(async_in[0:0]), .sample_tick(sample_tick),
    .stable_out(so_c), .settling(st_c)
`ifdef SOCETLIB_DEBOUNCER_EDGE_EN
    , .rise_pulse(rp_c), .fall_pulse(fp_c)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: input history, run length of differing qualified ticks, accepted level.
  logic [3:0] hist [3][4];
  int         run  [3][4];
  logic [3:0] mout [3];
  logic [3:0] mset [3];
  logic [3:0] mrise[3];
  logic [3:0] mfall[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        hist[k][j] = RV[k];
        run[k][j]  = 0;
      end
      mout[k]  = RV[k];
      mset[k]  = '0;
      mrise[k] = '0;
      mfall[k] = '0;
    end
  endtask

  // One rising edge: a level is accepted once it has differed for SC qualifying ticks in a row.
  task automatic model_edge(input logic [3:0] a, input logic t);
    logic [3:0] sv;
    for (int k = 0; k < 3; k++) begin
      sv       = hist[k][NS[k]-1];
      mset[k]  = '0;
      mrise[k] = '0;
      mfall[k] = '0;
      for (int b = 0; b < WD[k]; b++) begin
        if (sv[b] == mout[k][b]) begin
          run[k][b] = 0;
        end else begin
          if (t) run[k][b] = run[k][b] + 1;
          if (run[k][b] == SC[k]) begin
            mout[k][b] = sv[b];
            run[k][b]  = 0;
            if (sv[b]) mrise[k][b] = 1'b1;
            else       mfall[k][b] = 1'b1;
          end else begin
            mset[k][b] = 1'b1;
          end
        end
      end
      for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = (WD[k] == 1) ? {3'b000, a[0]} : a;
    end
  endtask

  function automatic logic [3:0] act_out(input int k);
    case (k)
      0:       return so_a;
      1:       return so_b;
      default: return {3'b000, so_c};
    endcase
  endfunction

  function automatic logic [3:0] act_set(input int k);
    case (k)
      0:       return st_a;
      1:       return st_b;
      default: return {3'b000, st_c};
    endcase
  endfunction

`ifdef SOCETLIB_DEBOUNCER_EDGE_EN
  function automatic logic [3:0] act_rise(input int k);
    case (k)
      0:       return rp_a;
      1:       return rp_b;
      default: return {3'b000, rp_c};
    endcase
  endfunction

  function automatic logic [3:0] act_fall(input int k);
    case (k)
      0:       return fp_a;
      1:       return fp_b;
      default: return {3'b000, fp_c};
    endcase
  endfunction
`endif

  task automatic compare_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (act_out(k) !== mout[k]) begin
        n_fail++;
        $display("FAIL %s inst%0d stable_out cyc %0d: got %b expected %b", tag, k, cyc, act_out(k), mout[k]);
      end
      n_checks++;
      if (act_set(k) !== mset[k]) begin
        n_fail++;
        $display("FAIL %s inst%0d settling cyc %0d: got %b expected %b", tag, k, cyc, act_set(k), mset[k]);
      end
`ifdef SOCETLIB_DEBOUNCER_EDGE_EN
      n_checks++;
      if (act_rise(k) !== mrise[k]) begin
        n_fail++;
        $display("FAIL %s inst%0d rise_pulse cyc %0d: got %b expected %b", tag, k, cyc, act_rise(k), mrise[k]);
      end
      n_checks++;
      if (act_fall(k) !== mfall[k]) begin
        n_fail++;
        $display("FAIL %s inst%0d fall_pulse cyc %0d: got %b expected %b", tag, k, cyc, act_fall(k), mfall[k]);
      end
`endif
    end
  endtask

  // Drive at the falling edge, let one rising edge happen, check at the next falling edge.
  task automatic tick_cycle(input logic [3:0] a, input logic t, input string tag);
    async_in    = a;
    sample_tick = t;
    @(posedge CLK);
    model_edge(a, t);
    @(negedge CLK);
    cyc++;
    compare_all(tag);
  endtask

  task automatic settle_to(input logic [3:0] a);
    for (int e = 0; e < 40; e++) tick_cycle(a, 1'b1, "settle");
  endtask

  task automatic test_reset();
    nRST        = 1'b0;
    async_in    = 4'($urandom);
    sample_tick = 1'b1;
    model_reset();
    @(negedge CLK);
    n_checks++;
    if (so_a !== 4'b0000 || so_b !== RV_B || so_c !== RV_C) begin
      n_fail++;
      $display("FAIL reset stable_out: got %b %b %b expected 0000 %b %b", so_a, so_b, so_c, RV_B, RV_C);
    end
    n_checks++;
    if (st_a !== 4'b0000 || st_b !== 4'b0000 || st_c !== 1'b0) begin
      n_fail++;
      $display("FAIL reset settling: got %b %b %b expected 0", st_a, st_b, st_c);
    end
    compare_all("reset");
    nRST = 1'b1;
  endtask

  task automatic test_clean_step();
    settle_to(4'b0000);
    for (int e = 1; e <= 25; e++) begin
      tick_cycle(4'b0001, 1'b1, "clean_step");
      n_checks++;
      if (so_a[0] !== (e >= 18) || st_a[0] !== (e >= 3 && e <= 17)) begin
        n_fail++;
        $display("FAIL clean_step edge %0d: got out=%b settling=%b expected out=%b settling=%b",
                 e, so_a[0], st_a[0], e >= 18, e >= 3 && e <= 17);
      end
    end
  endtask

  task automatic test_glitch();
    for (int e = 1; e <= 40; e++) begin
      tick_cycle(4'b0000, 1'b1, "fall_step");
`ifdef SOCETLIB_DEBOUNCER_EDGE_EN
      n_checks++;
      if (fp_a[0] !== (e == 18) || rp_a[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL fall_pulse edge %0d: got fall=%b rise=%b expected fall=%b rise=0", e, fp_a[0], rp_a[0], e == 18);
      end
`endif
    end
    for (int e = 1; e <= 30; e++) begin
      tick_cycle((e <= 10) ? 4'b0001 : 4'b0000, 1'b1, "glitch");
      n_checks++;
      if (so_a[0] !== 1'b0 || st_a[0] !== (e >= 3 && e <= 12)) begin
        n_fail++;
        $display("FAIL glitch edge %0d: got out=%b settling=%b expected out=0 settling=%b",
                 e, so_a[0], st_a[0], e >= 3 && e <= 12);
      end
    end
  endtask

  task automatic test_tick_gating();
    logic prev;
    settle_to(4'b0000);
    prev = so_b[2];
    for (int e = 1; e <= 24; e++) begin
      tick_cycle(4'b0100, (e % 4) == 0, "tick_gating");
      n_checks++;
      if (so_b[2] !== (e >= 16)) begin
        n_fail++;
        $display("FAIL tick_gating edge %0d: got %b expected %b", e, so_b[2], e >= 16);
      end
      if ((e % 4) != 0) begin
        n_checks++;
        if (so_b[2] !== prev) begin
          n_fail++;
          $display("FAIL tick_hold edge %0d: got %b expected %b", e, so_b[2], prev);
        end
      end
      prev = so_b[2];
    end
  endtask

  task automatic test_reset_mid_settle();
    settle_to(4'b0000);
    for (int e = 1; e <= 12; e++) tick_cycle(4'b1111, 1'b1, "pre_reset");
    nRST = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (so_a !== 4'b0000 || st_a !== 4'b0000 || so_b !== RV_B) begin
      n_fail++;
      $display("FAIL mid_reset: got out=%b settling=%b outb=%b expected 0000 0000 %b", so_a, st_a, so_b, RV_B);
    end
    compare_all("mid_reset");
    #2 nRST = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      tick_cycle(4'b1111, 1'b1, "after_reset");
      n_checks++;
      if (so_a !== ((e >= 18) ? 4'b1111 : 4'b0000)) begin
        n_fail++;
        $display("FAIL after_reset edge %0d: got %b expected %b", e, so_a, (e >= 18) ? 4'b1111 : 4'b0000);
      end
    end
  endtask

  task automatic test_multibit();
    logic [3:0] a;
    logic [3:0] exp_o;
    settle_to(4'b0000);
    for (int e = 1; e <= 32; e++) begin
      a = {e >= 6, 1'b0, ((e - 1) / 3) % 2 == 1, 1'b1};
      tick_cycle(a, 1'b1, "multibit");
      exp_o = {e >= 23, 1'b0, 1'b0, e >= 18};
      n_checks++;
      if (so_a !== exp_o) begin
        n_fail++;
        $display("FAIL multibit edge %0d: got %b expected %b", e, so_a, exp_o);
      end
`ifdef SOCETLIB_DEBOUNCER_EDGE_EN
      n_checks++;
      if (rp_a !== {e == 23, 1'b0, 1'b0, e == 18} || fp_a !== 4'b0000) begin
        n_fail++;
        $display("FAIL multibit_pulse edge %0d: got rise=%b fall=%b", e, rp_a, fp_a);
      end
`endif
    end
  endtask

  // Random per-bit hold lengths straddling every window, random tick gating, rare resets.
  task automatic test_random();
    logic [3:0] a;
    int         hold [4];
    a = 4'b0000;
    for (int b = 0; b < 4; b++) hold[b] = 1;
    for (int e = 0; e < 3000; e++) begin
      for (int b = 0; b < 4; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          a[b]    = ~a[b];
          hold[b] = int'($urandom_range(1, 24));
        end
      end
      if ($urandom_range(0, 499) == 0) begin
        nRST = 1'b0;
        #1;
        model_reset();
        compare_all("random_reset");
        #2 nRST = 1'b1;
      end
      tick_cycle(a, $urandom_range(0, 3) != 0, "random");
    end
  endtask

  initial begin
    nRST        = 1'b0;
    async_in    = '0;
    sample_tick = 1'b1;
    test_reset();
    test_clean_step();
    test_glitch();
    test_tick_gating();
    test_reset_mid_settle();
    test_multibit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
